bounce_generator: RTL and testbench



---
 rtl/bounce_pkg.sv | 16 +
 rtl/lfsr8.sv | 24 ++
 rtl/bounce_generator.sv | 151 +++++++++++++++
 tb/tb_bounce_generator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce generator and its LFSR.
package bounce_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBounce = 2'd1,
    StSettle = 2'd2
  } bounce_state_t;

  // Fibonacci taps 8,6,5,4 expressed as state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam int unsigned REM_W = 5;
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; advances on every clock.
module lfsr8
  import bounce_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [7:0] o_state
);

  logic [7:0] state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= {state_q[6:0], ^(state_q & LFSR_TAPS)};
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/bounce_generator.sv
// Turns a clean level into a bouncing burst of 2N+1 randomly spaced transitions,
// then holds for a settle period. Counts every output transition.
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000,
  parameter int unsigned SETTLE_TICKS = 16,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_lvl,
  input  logic [3:0]       i_bounce_cnt,
  output logic             o_lvl,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_toggle_count,
  output logic [1:0]       o_state
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SET_W = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam logic [PRE_W-1:0] PreMax     = PRE_W'(TICK_DIV - 1);
  localparam logic [SET_W-1:0] SettleLoad = SET_W'(SETTLE_TICKS);

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic [7:0]       lfsr;
  logic             unused_lfsr;

  bounce_state_t    state_q;
  logic             lvl_q, lvl_d;
  logic             busy_q;
  logic [REM_W-1:0] rem_q;
  logic [3:0]       ival_q;
  logic [SET_W-1:0] settle_q;
  logic [CNT_W-1:0] cnt_q;
  logic             event_hit;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_state (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:3];

  assign tick = (pre_q == PreMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  assign event_hit = (state_q == StBounce) && tick && (ival_q == 4'd1);

  // Next output level; shared by the level register and the transition counter.
  always_comb begin
    lvl_d = lvl_q;
    if (!i_en) begin
      lvl_d = i_lvl;
    end else if (event_hit) begin
      lvl_d = (rem_q > REM_W'(1)) ? ~lvl_q : i_lvl;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      lvl_q    <= 1'b0;
      busy_q   <= 1'b0;
      rem_q    <= '0;
      ival_q   <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
    end else begin
      lvl_q <= lvl_d;

      if (i_clr) begin
        cnt_q <= '0;
      end else if (lvl_d != lvl_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (!i_en) begin
        state_q  <= StIdle;
        busy_q   <= 1'b0;
        rem_q    <= '0;
        ival_q   <= '0;
        settle_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_lvl != lvl_q) begin
              state_q <= StBounce;
              busy_q  <= 1'b1;
              rem_q   <= {i_bounce_cnt, 1'b1};
              ival_q  <= {1'b0, lfsr[2:0]} + 4'd1;
            end
          end
          StBounce: begin
            if (tick) begin
              if (ival_q == 4'd1) begin
                if (rem_q > REM_W'(1)) begin
                  rem_q  <= rem_q - REM_W'(1);
                  ival_q <= {1'b0, lfsr[2:0]} + 4'd1;
                end else begin
                  state_q  <= StSettle;
                  settle_q <= SettleLoad;
                  rem_q    <= '0;
                  ival_q   <= '0;
                end
              end else begin
                ival_q <= ival_q - 4'd1;
              end
            end
          end
          StSettle: begin
            if (tick) begin
              if (settle_q <= SET_W'(1)) begin
                state_q  <= StIdle;
                busy_q   <= 1'b0;
                settle_q <= '0;
              end else begin
                settle_q <= settle_q - SET_W'(1);
              end
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_lvl          = lvl_q;
  assign o_busy         = busy_q;
  assign o_toggle_count = cnt_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator with TICK_DIV=1, SETTLE_TICKS=4, LFSR_SEED=8'hA5.
module tb_bounce_generator;

  logic       clk;
  logic       rst_n;
  logic       i_clr;
  logic       i_en;
  logic       i_lvl;
  logic [3:0] i_bounce_cnt;
  logic       o_lvl;
  logic       o_busy;
  logic [7:0] o_toggle_count;
  logic [1:0] o_state;

  int         n_checks;
  int         n_errors;
  logic [7:0] m;        // reference LFSR
  int         exp_cnt;
  logic       cur_lvl;

  bounce_generator #(
    .TICK_DIV     (1),
    .SETTLE_TICKS (4),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_clr          (i_clr),
    .i_en           (i_en),
    .i_lvl          (i_lvl),
    .i_bounce_cnt   (i_bounce_cnt),
    .o_lvl          (o_lvl),
    .o_busy         (o_busy),
    .o_toggle_count (o_toggle_count),
    .o_state        (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 8'hA5;
    else        m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge. Drives a burst and follows it event by event.
  task automatic run_burst(input logic [3:0] n, input logic tgt, input int flip_after,
                           input logic flip_lvl);
    int   k;
    int   kn;
    int   total;
    logic exp;
    exp          = cur_lvl;
    kn           = 1;
    i_en         = 1'b1;
    i_bounce_cnt = n;
    i_lvl        = tgt;
    k            = int'(m[2:0]) + 1;
    @(negedge clk);
    check_eq("burst_state", 32'(o_state), 32'd1);
    check_eq("burst_busy", 32'(o_busy), 32'd1);
    total = 2 * int'(n) + 1;
    for (int ev = 1; ev <= total; ev++) begin
      for (int j = 1; j <= k; j++) begin
        if (j == k) kn = int'(m[2:0]) + 1;
        @(negedge clk);
        if (j < k) check_eq("hold", 32'(o_lvl), 32'(exp));
      end
      if (ev < total) exp = ~exp;
      else            exp = i_lvl;
      if (exp != cur_lvl) exp_cnt++;
      cur_lvl = exp;
      check_eq("toggle", 32'(o_lvl), 32'(exp));
      if (ev == flip_after) i_lvl = flip_lvl;
      k = kn;
    end
    check_eq("settle_state", 32'(o_state), 32'd2);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_eq("settle_busy", 32'(o_busy), 32'd1);
    end
    @(negedge clk);
    check_eq("idle_busy", 32'(o_busy), 32'd0);
    check_eq("idle_state", 32'(o_state), 32'd0);
    check_eq("burst_count", 32'(o_toggle_count), 32'(exp_cnt[7:0]));
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_eq("no_rebounce", 32'(o_state), 32'd0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_cnt      = 0;
    cur_lvl      = 1'b0;
    rst_n        = 1'b0;
    i_clr        = 1'b0;
    i_en         = 1'b0;
    i_lvl        = 1'b0;
    i_bounce_cnt = 4'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_lvl", 32'(o_lvl), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_count", 32'(o_toggle_count), 32'd0);
    check_eq("rst_state", 32'(o_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass-through
    i_lvl = 1'b1;
    @(negedge clk);
    check_eq("pass_lvl", 32'(o_lvl), 32'd1);
    check_eq("pass_count", 32'(o_toggle_count), 32'd1);
    check_eq("pass_busy", 32'(o_busy), 32'd0);
    i_lvl = 1'b0;
    @(negedge clk);
    check_eq("pass_lvl0", 32'(o_lvl), 32'd0);
    check_eq("pass_count2", 32'(o_toggle_count), 32'd2);
    check_eq("pass_busy2", 32'(o_busy), 32'd0);
    exp_cnt = 2;
    cur_lvl = 1'b0;

    run_burst(4'd3, 1'b1, 0, 1'b0);
    check_eq("n3_final_lvl", 32'(o_lvl), 32'd1);
    check_eq("n3_count", 32'(o_toggle_count), 32'd9);

    run_burst(4'd0, 1'b0, 0, 1'b0);
    check_eq("n0_final_lvl", 32'(o_lvl), 32'd0);
    check_eq("n0_count", 32'(o_toggle_count), 32'd10);

    // Target reverts after the 2nd toggle: 10 toggles, forced write is a no-op
    run_burst(4'd5, 1'b1, 2, 1'b0);
    check_eq("flip_final_lvl", 32'(o_lvl), 32'd0);
    check_eq("flip_count", 32'(o_toggle_count), 32'd20);

    // Reset mid-burst
    i_en         = 1'b1;
    i_bounce_cnt = 4'd7;
    i_lvl        = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_state", 32'(o_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_lvl", 32'(o_lvl), 32'd0);
    check_eq("mid_rst_count", 32'(o_toggle_count), 32'd0);
    check_eq("mid_rst_state", 32'(o_state), 32'd0);
    check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_hold_state", 32'(o_state), 32'd0);
      check_eq("rst_hold_count", 32'(o_toggle_count), 32'd0);
      check_eq("rst_hold_lvl", 32'(o_lvl), 32'd0);
    end
    i_en  = 1'b0;
    i_lvl = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Clear coincident with a transition
    i_lvl = 1'b1;
    @(negedge clk);
    check_eq("pre_clr_count", 32'(o_toggle_count), 32'd1);
    i_lvl = 1'b0;
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    check_eq("clr_lvl", 32'(o_lvl), 32'd0);
    check_eq("clr_count", 32'(o_toggle_count), 32'd0);

    // 256 pass-through transitions wrap the counter
    for (int i = 1; i <= 256; i++) begin
      i_lvl = ~i_lvl;
      @(negedge clk);
      if (i == 255) check_eq("count_255", 32'(o_toggle_count), 32'd255);
    end
    check_eq("count_wrap", 32'(o_toggle_count), 32'd0);
    check_eq("wrap_lvl", 32'(o_lvl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
